count_bus_monitor: RTL and testbench

- Receive-side checker for the 8-bit tri-state count bus driven by the programmable counter.
- The counter increments once per clock, so the monitor keeps its own free-running expected value and compares it with each valid bus sample.
- It reports lock, continuity errors and wrap-arounds. It sits on the same clock as the counter, next to the pad or bus logic.
- Loads announced with load_hint resynchronise the monitor without being counted as errors.

---
 rtl/count_bus_monitor_if.sv | 37 +++
 rtl/count_bus_monitor.sv | 169 ++++++++++++++++
 tb/tb_count_bus_monitor.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/count_bus_monitor_if.sv
// Count bus bundle: sampled bus and clear toward the monitor, lock/error status back.
// COUNT_BUS_MONITOR_CAPTURE_EN adds the err_data/err_expect capture signals.
interface count_bus_monitor_if #(
  parameter int WIDTH  = 8,
  parameter int STAT_W = 8
);
  logic              bus_valid;
  logic [WIDTH-1:0]  bus_data;
  logic              load_hint;
  logic              clear;
  logic              locked;
  logic              err_pulse;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;
`ifdef COUNT_BUS_MONITOR_CAPTURE_EN
  logic [WIDTH-1:0]  err_data;
  logic [WIDTH-1:0]  err_expect;

  modport master (
    output bus_valid, bus_data, load_hint, clear,
    input  locked, err_pulse, err_count, wrap_count, err_data, err_expect
  );
  modport slave (
    input  bus_valid, bus_data, load_hint, clear,
    output locked, err_pulse, err_count, wrap_count, err_data, err_expect
  );
`else
  modport master (
    output bus_valid, bus_data, load_hint, clear,
    input  locked, err_pulse, err_count, wrap_count
  );
  modport slave (
    input  bus_valid, bus_data, load_hint, clear,
    output locked, err_pulse, err_count, wrap_count
  );
`endif
endinterface

// File: rtl/count_bus_monitor.sv
// Receive-side checker for the free-running count bus: tracks lock, continuity errors and wraps.
// Define COUNT_BUS_MONITOR_CAPTURE_EN to capture bus/expected values of the latest mismatch.
module count_bus_monitor #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4,
  parameter int STAT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  count_bus_monitor_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]  EXP_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  EXP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        LOCK_TGT = 4'(LOCK_CNT);
  localparam bit                LOCK_ONE = (LOCK_CNT == 1);

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    if (v == STAT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + STAT_ONE;
    end
  endfunction

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  expected_q, expected_d;
  logic [3:0]        match_cnt_q, match_cnt_d;
  logic              sample_s, match_s, ref_load_s, err_s, wrap_s;
  logic              locked_q, err_pulse_q, wrap_pend_q;
  logic [STAT_W-1:0] err_count_q, wrap_count_q;

  assign sample_s = bus.bus_valid;
  assign match_s  = (bus.bus_data == expected_q);

  // State, expected value and match counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      expected_q  <= {WIDTH{1'b0}};
      match_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (sample_s) state_d = LOCK_ONE ? LOCKED : ACQUIRE;
        else          state_d = IDLE;
      end
      ACQUIRE: begin
        if (sample_s && !bus.load_hint && match_s && ((match_cnt_q + 4'd1) >= LOCK_TGT))
          state_d = LOCKED;
        else
          state_d = ACQUIRE;
      end
      LOCKED: begin
        if (sample_s && !bus.load_hint && !match_s) state_d = ACQUIRE;
        else                                        state_d = LOCKED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath decode: reference loads, match counting, error and wrap events
  always_comb begin
    ref_load_s  = 1'b0;
    match_cnt_d = match_cnt_q;
    err_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_s) begin
          ref_load_s  = 1'b1;
          match_cnt_d = LOCK_ONE ? 4'd0 : 4'd1;
        end else begin
          ref_load_s  = 1'b0;
        end
      end
      ACQUIRE: begin
        if (sample_s && (bus.load_hint || !match_s)) begin
          ref_load_s  = 1'b1;
          match_cnt_d = 4'd1;
        end else if (sample_s) begin
          match_cnt_d = match_cnt_q + 4'd1;
        end else begin
          match_cnt_d = match_cnt_q;
        end
      end
      LOCKED: begin
        if (sample_s && bus.load_hint) begin
          ref_load_s  = 1'b1;
        end else if (sample_s && !match_s) begin
          ref_load_s  = 1'b1;
          match_cnt_d = 4'd1;
          err_s       = 1'b1;
        end else begin
          ref_load_s  = 1'b0;
        end
      end
      default: begin
        match_cnt_d = 4'd0;
      end
    endcase
    expected_d = ref_load_s ? (bus.bus_data + EXP_ONE) : (expected_q + EXP_ONE);
    // Only a free-running roll-over while locked counts as a wrap
    wrap_s = (state_q == LOCKED) && !ref_load_s && (expected_q == EXP_MAX);
  end

  // Registered status outputs; the wrap is reported one cycle after expected reaches zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pend_q  <= 1'b0;
      err_count_q  <= {STAT_W{1'b0}};
      wrap_count_q <= {STAT_W{1'b0}};
    end else begin
      locked_q    <= (state_d == LOCKED);
      err_pulse_q <= err_s;
      wrap_pend_q <= wrap_s;
      if (bus.clear) begin
        err_count_q  <= {STAT_W{1'b0}};
        wrap_count_q <= {STAT_W{1'b0}};
      end else begin
        if (err_s)       err_count_q  <= sat_inc(err_count_q);
        if (wrap_pend_q) wrap_count_q <= sat_inc(wrap_count_q);
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_pulse_q;
  assign bus.err_count  = err_count_q;
  assign bus.wrap_count = wrap_count_q;

`ifdef COUNT_BUS_MONITOR_CAPTURE_EN
  logic [WIDTH-1:0] err_data_q, err_expect_q;

  // Capture of the most recent locked mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_data_q   <= {WIDTH{1'b0}};
      err_expect_q <= {WIDTH{1'b0}};
    end else if (bus.clear) begin
      err_data_q   <= {WIDTH{1'b0}};
      err_expect_q <= {WIDTH{1'b0}};
    end else if (err_s) begin
      err_data_q   <= bus.bus_data;
      err_expect_q <= expected_q;
    end
  end

  assign bus.err_data   = err_data_q;
  assign bus.err_expect = err_expect_q;
`endif
endmodule

// File: tb/tb_count_bus_monitor.sv
// Scoreboard bench for count_bus_monitor: directed scenarios plus randomized count streams.
module tb_count_bus_monitor;
  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 4;
  localparam int STAT_W   = 8;
  localparam int MODV     = 1 << WIDTH;
  localparam int SMAX     = (1 << STAT_W) - 1;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCKED = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  count_bus_monitor_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus_if ();

  count_bus_monitor #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .STAT_W(STAT_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  typedef struct {
    int due;
    int locked;
    int errp;
    int ec;
    int wc;
    int ed;
    int ee;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state, expressed as plain integers
  int m_state, m_exp, m_mc, m_ec, m_wc, m_wrap_pend, m_ed, m_ee;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_exp = 0; m_mc = 0; m_ec = 0; m_wc = 0;
    m_wrap_pend = 0; m_ed = 0; m_ee = 0;
  endtask

  task automatic model_step(input int v, input int d, input int h, input int c);
    int   nstate = m_state;
    bit   reload = 0;
    bit   err    = 0;
    bit   wrap_now;
    exp_t e;
    if (v != 0) begin
      if (m_state == M_IDLE) begin
        reload = 1;
        m_mc   = (LOCK_CNT == 1) ? 0 : 1;
        nstate = (LOCK_CNT == 1) ? M_LOCKED : M_ACQ;
      end else if (m_state == M_ACQ) begin
        if (h != 0 || d != m_exp) begin
          reload = 1;
          m_mc   = 1;
        end else begin
          m_mc = m_mc + 1;
          if (m_mc >= LOCK_CNT) nstate = M_LOCKED;
        end
      end else begin
        if (h != 0) reload = 1;
        else if (d != m_exp) begin
          reload = 1; err = 1; m_mc = 1; nstate = M_ACQ;
        end
      end
    end
    wrap_now = (m_state == M_LOCKED) && !reload && (m_exp == MODV - 1);
    if (c != 0) begin
      m_ec = 0; m_wc = 0; m_ed = 0; m_ee = 0;
    end else begin
      if (err && m_ec < SMAX) m_ec++;
      if (m_wrap_pend != 0 && m_wc < SMAX) m_wc++;
      if (err) begin m_ed = d; m_ee = m_exp; end
    end
    m_exp       = reload ? (d + 1) % MODV : (m_exp + 1) % MODV;
    m_state     = nstate;
    m_wrap_pend = wrap_now;
    e.due = cyc + 1; e.locked = (m_state == M_LOCKED); e.errp = err;
    e.ec = m_ec; e.wc = m_wc; e.ed = m_ed; e.ee = m_ee;
    sb_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, log the expected response, and move past the next edge
  task automatic step(input int v, input int d, input int h = 0, input int c = 0);
    bus_if.bus_valid = (v != 0);
    bus_if.bus_data  = 8'(d);
    bus_if.load_hint = (h != 0);
    bus_if.clear     = (c != 0);
    model_step(v, d, h, c);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare DUT outputs against the oldest due scoreboard entry
  always @(negedge clk) begin
    if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      mon_e = sb_q.pop_front();
      chk("sb_locked",     bus_if.locked,     mon_e.locked);
      chk("sb_err_pulse",  bus_if.err_pulse,  mon_e.errp);
      chk("sb_err_count",  bus_if.err_count,  mon_e.ec);
      chk("sb_wrap_count", bus_if.wrap_count, mon_e.wc);
`ifdef COUNT_BUS_MONITOR_CAPTURE_EN
      chk("sb_err_data",   bus_if.err_data,   mon_e.ed);
      chk("sb_err_expect", bus_if.err_expect, mon_e.ee);
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  initial begin
    int src, d, r, v, h, c;
    bus_if.bus_valid = 1'b0;
    bus_if.bus_data  = 8'd0;
    bus_if.load_hint = 1'b0;
    bus_if.clear     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_locked",     bus_if.locked,     0);
    chk("reset_err_pulse",  bus_if.err_pulse,  0);
    chk("reset_err_count",  bus_if.err_count,  0);
    chk("reset_wrap_count", bus_if.wrap_count, 0);
    rst_n = 1'b1;

    // Lock on 10..13
    for (int i = 10; i <= 13; i++) step(1, i);
    chk("lock_locked", bus_if.locked, 1);
    chk("lock_err_count", bus_if.err_count, 0);

    // Gap of five idle cycles, then the continuing count
    repeat (5) step(0, 0);
    step(1, 19);
    chk("gap_locked", bus_if.locked, 1);
    chk("gap_err_pulse", bus_if.err_pulse, 0);
    step(1, 20);
    step(1, 18);
    chk("mism_err_pulse", bus_if.err_pulse, 1);
    chk("mism_err_count", bus_if.err_count, 1);
    chk("mism_locked", bus_if.locked, 0);
    for (int i = 19; i <= 40; i++) step(1, i);
    chk("relock_locked", bus_if.locked, 1);

    // Announced load
    step(1, 200, 1);
    chk("load_locked", bus_if.locked, 1);
    chk("load_err_pulse", bus_if.err_pulse, 0);
    step(1, 201);
    chk("load_next_locked", bus_if.locked, 1);

    // Continuous count through the wrap
    for (int i = 202; i <= 255; i++) step(1, i);
    chk("wrap_before", bus_if.wrap_count, 0);
    step(1, 0);
    chk("wrap_after", bus_if.wrap_count, 1);
    chk("wrap_err_count", bus_if.err_count, 1);
    step(1, 1);

    // Saturate err_count with 300 mismatch/relock rounds
    src = 2;
    for (int i = 0; i < 300; i++) begin
      d = (src + 100) % MODV;
      step(1, d);
      for (int k = 1; k <= 3; k++) step(1, (d + k) % MODV);
      src = (d + 4) % MODV;
    end
    chk("sat_err_count", bus_if.err_count, 255);
    step(1, (src + 50) % MODV, 0, 1);
    chk("clear_err_count", bus_if.err_count, 0);
    chk("clear_err_pulse", bus_if.err_pulse, 1);

    // Randomized stream: gaps, corruptions, announced loads, clears
    src = $urandom_range(0, MODV - 1);
    for (int i = 0; i < 2000; i++) begin
      r = $urandom_range(0, 99);
      v = (r < 80);
      h = (r < 4) || (r >= 95);
      c = ($urandom_range(0, 49) == 0);
      if (v != 0 && h != 0) src = $urandom_range(0, MODV - 1);
      d = src;
      if (v != 0 && r >= 4 && r < 9) d = d ^ (1 << $urandom_range(0, WIDTH - 1));
      step(v, d, h, c);
      src = (src + 1) % MODV;
    end

    // Relock, then asynchronous reset between edges
    for (int i = 60; i <= 70; i++) step(1, i);
    chk("prereset_locked", bus_if.locked, 1);
    @(negedge clk);
    #1;
    bus_if.bus_valid = 1'b0;
    bus_if.load_hint = 1'b0;
    bus_if.clear     = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("areset_locked",     bus_if.locked,     0);
    chk("areset_err_pulse",  bus_if.err_pulse,  0);
    chk("areset_err_count",  bus_if.err_count,  0);
    chk("areset_wrap_count", bus_if.wrap_count, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 77);
    chk("restart_locked", bus_if.locked, 0);
    for (int i = 78; i <= 82; i++) step(1, i);
    chk("restart_relock", bus_if.locked, 1);
    step(0, 0);

    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    #1;
    chk("drain", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
